// File: rtl/muldiv_arbiter.sv
// ---------------------------------------------------------------------------
// muldiv_arbiter
//
// Purpose:
//   Shares a single iterative multiply/divide unit between NUM_REQ requesters.
//   Requesters are picked round-robin. The chosen command's op and operands are
//   latched, and the unit's valid/ready (command) and valid/yumi (result)
//   handshakes are sequenced. The result is then held on the granted
//   requester's response channel until that requester consumes it. Only one
//   operation is in flight at a time.
//
// Parameters:
//   NUM_REQ  number of requesters (>= 2)
//   WIDTH    operand / result width
//
// Ports:
//   clk_i, rst_i      clock (rising edge) and asynchronous active-high reset
//   req_valid_i       per-requester command valid
//   req_ready_o       per-requester command accept (one-hot or zero, IDLE only)
//   req_op_i          per-requester op: 0 MUL, 1 DIV, 2 REM, 3 treated as MUL
//   req_a_i, req_b_i  per-requester signed operands, packed WIDTH*NUM_REQ
//   resp_valid_o      per-requester result valid (one-hot or zero)
//   resp_data_o       shared result bus, meaningful only with resp_valid_o
//   resp_yumi_i       per-requester result consume (only the granted bit counts)
//   unit_v_o / unit_ready_i           command handshake to the unit
//   unit_op_o, unit_a_o, unit_b_o     latched command to the unit
//   unit_v_i / unit_yumi_o            result handshake from the unit
//   unit_result_i                     unit result
//
// Configuration:
//   MULDIV_ARB_DIVZERO_EN  when defined, a DIV/REM with B == 0 bypasses the unit.
//                          DIV returns all-ones and REM returns A, one cycle
//                          after accept. When undefined, such ops go to the unit
//                          like any other op.
// ---------------------------------------------------------------------------
module muldiv_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [2*NUM_REQ-1:0]     req_op_i,
    input  logic [WIDTH*NUM_REQ-1:0] req_a_i,
    input  logic [WIDTH*NUM_REQ-1:0] req_b_i,
    output logic [NUM_REQ-1:0]       resp_valid_o,
    output logic [WIDTH-1:0]         resp_data_o,
    input  logic [NUM_REQ-1:0]       resp_yumi_i,
    output logic                     unit_v_o,
    input  logic                     unit_ready_i,
    output logic [1:0]               unit_op_o,
    output logic [WIDTH-1:0]         unit_a_o,
    output logic [WIDTH-1:0]         unit_b_o,
    input  logic                     unit_v_i,
    input  logic [WIDTH-1:0]         unit_result_i,
    output logic                     unit_yumi_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_DIV = 2'd1;
    localparam logic [1:0] OP_REM = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   grant_q, grant_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               unit_v_q, unit_v_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    logic               sel_found;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W:0]     cand;
    logic [1:0]         sel_op_raw;
    logic [1:0]         sel_op;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;

    always_comb begin
        // NOTE: every variable written here is defaulted first, so no path leaves it unassigned and infers a latch.
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!sel_found && req_valid_i[cand[PTR_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign sel_op_raw = req_op_i[int'(sel_idx)*2 +: 2];
    // The reserved op code is folded into MUL here, so the unit never sees it.
    assign sel_op     = (sel_op_raw == 2'd3) ? OP_MUL : sel_op_raw;
    assign sel_a      = req_a_i[int'(sel_idx)*WIDTH +: WIDTH];
    assign sel_b      = req_b_i[int'(sel_idx)*WIDTH +: WIDTH];

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        unit_v_d     = unit_v_q;
        resp_valid_d = resp_valid_q;
        req_ready_o  = '0;
        unit_yumi_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Ready is gated by rst_i so outputs stay zero while reset is held.
                if (sel_found && !rst_i) begin
                    req_ready_o[sel_idx] = 1'b1;
                    grant_d  = sel_idx;
                    op_d     = sel_op;
                    a_d      = sel_a;
                    b_d      = sel_b;
                    state_d  = S_ISSUE;
                    unit_v_d = 1'b1;
`ifdef MULDIV_ARB_DIVZERO_EN
                    if ((sel_op == OP_DIV || sel_op == OP_REM) && sel_b == '0) begin
                        state_d      = S_RESP;
                        unit_v_d     = 1'b0;
                        result_d     = (sel_op == OP_DIV) ? '1 : sel_a;
                        resp_valid_d = NUM_REQ'(1) << sel_idx;
                    end
`endif
                end
            end
            S_ISSUE: begin
                if (unit_ready_i) begin
                    unit_v_d = 1'b0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (unit_v_i) begin
                    unit_yumi_o  = 1'b1;
                    result_d     = unit_result_i;
                    resp_valid_d = NUM_REQ'(1) << grant_q;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_yumi_i[grant_q]) begin
                    resp_valid_d = '0;
                    rr_ptr_d     = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the datapath registers are reset as well, because they drive outputs that must read zero in reset.
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            unit_v_q     <= 1'b0;
            resp_valid_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            unit_v_q     <= unit_v_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign unit_v_o     = unit_v_q;
    assign unit_op_o    = op_q;
    assign unit_a_o     = a_q;
    assign unit_b_o     = b_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = result_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_muldiv_arbiter
//
// Purpose:
//   Self-checking bench for muldiv_arbiter (NUM_REQ=2, WIDTH=32). A behavioural
//   multiply/divide unit with random handshake timing answers the arbiter. The
//   expected grant order comes from a cyclic-priority model. Expected results
//   come from plain signed arithmetic on the operands each requester presented.
//   When MULDIV_ARB_DIVZERO_EN is defined, the same define must also be given
//   to this bench.
// ---------------------------------------------------------------------------
module tb_muldiv_arbiter;

    localparam int N = 2;
    localparam int W = 32;
`ifdef MULDIV_ARB_DIVZERO_EN
    localparam bit DZ_MODE = 1'b1;
`else
    localparam bit DZ_MODE = 1'b0;
`endif

    logic           clk;
    logic           rst_i;
    logic [N-1:0]   req_valid_i;
    logic [N-1:0]   req_ready_o;
    logic [2*N-1:0] req_op_i;
    logic [W*N-1:0] req_a_i;
    logic [W*N-1:0] req_b_i;
    logic [N-1:0]   resp_valid_o;
    logic [W-1:0]   resp_data_o;
    logic [N-1:0]   resp_yumi_i;
    logic           unit_v_o;
    logic           unit_ready_i;
    logic [1:0]     unit_op_o;
    logic [W-1:0]   unit_a_o;
    logic [W-1:0]   unit_b_o;
    logic           unit_v_i;
    logic [W-1:0]   unit_result_i;
    logic           unit_yumi_o;

    logic [1:0]     r_op [N];
    logic [W-1:0]   r_a  [N];
    logic [W-1:0]   r_b  [N];

    int n_tests = 0;
    int n_fail  = 0;
    int m_ptr   = 0;       // model round-robin pointer
    int unit_issues = 0;   // commands accepted by the unit model
    bit slow = 1'b0;       // unit model: always ready, long latency
    bit spur = 1'b0;       // unit model: raise unit_v_i while it holds no op

    muldiv_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .resp_yumi_i  (resp_yumi_i),
        .unit_v_o     (unit_v_o),
        .unit_ready_i (unit_ready_i),
        .unit_op_o    (unit_op_o),
        .unit_a_o     (unit_a_o),
        .unit_b_o     (unit_b_o),
        .unit_v_i     (unit_v_i),
        .unit_result_i(unit_result_i),
        .unit_yumi_o  (unit_yumi_o)
    );

    always_comb begin
        req_op_i = '0;
        req_a_i  = '0;
        req_b_i  = '0;
        for (int i = 0; i < N; i++) begin
            req_op_i[2*i +: 2] = r_op[i];
            req_a_i[W*i +: W]  = r_a[i];
            req_b_i[W*i +: W]  = r_b[i];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    // Signed arithmetic for ops 0..2; any other code yields a marker value.
    function automatic logic [W-1:0] arith(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic signed [W-1:0] r;
        sa = a;
        sb = b;
        case (op)
            2'd0:    r = sa * sb;
            2'd1:    r = (b == '0) ? '1 : sa / sb;
            2'd2:    r = (b == '0) ? sa : sa % sb;
            default: r = W'(32'hDEAD_BEEF);
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        return arith((op == 2'd3) ? 2'd0 : op, a, b);
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rnd_opnd(input bit allow_zero);
        if (allow_zero && $urandom_range(0, 4) == 0) return '0;
        return W'($urandom_range(0, 2000)) - W'(1000);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural unit: accepts a command when ready, answers after a delay,
    // and holds its result until yumi.
    initial begin : unit_model
        bit           u_have;
        int           u_cnt;
        logic [W-1:0] u_res;
        u_have = 1'b0;
        u_cnt  = 0;
        u_res  = '0;
        unit_ready_i  = 1'b0;
        unit_v_i      = 1'b0;
        unit_result_i = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                u_have       = 1'b0;
                unit_v_i     = 1'b0;
                unit_ready_i = 1'b0;
            end else begin
                unit_ready_i = !u_have && (slow || $urandom_range(0, 3) != 0);
                if (u_have && u_cnt == 0) begin
                    unit_v_i      = 1'b1;
                    unit_result_i = u_res;
                end else if (!u_have && spur) begin
                    unit_v_i      = 1'b1;
                    unit_result_i = W'(32'h5A5A_5A5A);
                end else begin
                    unit_v_i = 1'b0;
                end
                #1;
                if (!u_have && unit_v_o && unit_ready_i) begin
                    u_have = 1'b1;
                    u_cnt  = slow ? 10 : int'($urandom_range(0, 4));
                    u_res  = arith(unit_op_o, unit_a_o, unit_b_o);
                    unit_issues++;
                end else if (u_have && unit_v_i && unit_yumi_o) begin
                    u_have = 1'b0;
                end else if (u_have && u_cnt > 0) begin
                    u_cnt--;
                end
            end
        end
    end

    // Runs one operation from grant through consume. Entered just after a negedge.
    task automatic serve(input bit keep, input int yumi_wait, output int g_obs, output logic [W-1:0] d_obs);
        int           cyc;
        int           g_exp;
        logic [W-1:0] exp_res;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           dz;
        int           issues0;
        #1;
        cyc = 0;
        while (req_ready_o == '0 && cyc < 100) begin
            @(negedge clk); #1; cyc++;
        end
        g_exp = pick(req_valid_i, m_ptr);
        g_obs = -1;
        for (int i = 0; i < N; i++) if (req_ready_o[i]) g_obs = i;
        check("ready_grant", 64'(req_ready_o), 64'(N'(1) << g_exp));
        op      = r_op[g_exp];
        a       = r_a[g_exp];
        b       = r_b[g_exp];
        exp_res = ref_result(op, a, b);
        dz      = DZ_MODE && (op == 2'd1 || op == 2'd2) && b == '0;
        issues0 = unit_issues;
        @(negedge clk);
        if (keep) begin
            r_op[g_exp] = 2'($urandom_range(0, 3));
            r_a[g_exp]  = rnd_opnd(1'b0);
            r_b[g_exp]  = rnd_opnd(1'b1);
        end else begin
            req_valid_i[g_exp] = 1'b0;
        end
        #1;
        check("ready_pulse", 64'(req_ready_o), 64'd0);
        check("yumi_outside_busy", 64'(unit_yumi_o), 64'd0);
        if (dz) begin
            check("dz_resp_1cyc", 64'(resp_valid_o), 64'(N'(1) << g_exp));
            check("dz_no_unit_v", 64'(unit_v_o), 64'd0);
        end else begin
            check("issue_v", 64'(unit_v_o), 64'd1);
            check("issue_op", 64'(unit_op_o), 64'((op == 2'd3) ? 2'd0 : op));
            check("issue_a", 64'(unit_a_o), 64'(a));
            check("issue_b", 64'(unit_b_o), 64'(b));
        end
        cyc = 1;
        while (resp_valid_o == '0 && cyc < 100) begin
            @(negedge clk); #1; cyc++;
        end
        if (!dz) check("latency_min3", 64'(cyc >= 3), 64'd1);
        check("resp_valid", 64'(resp_valid_o), 64'(N'(1) << g_exp));
        check("resp_data", 64'(resp_data_o), 64'(exp_res));
        d_obs = resp_data_o;
        for (int k = 0; k < yumi_wait; k++) begin
            // Consume strobes on the other requesters' bits must be ignored.
            resp_yumi_i = ~(N'(1) << g_exp) & N'($urandom);
            @(negedge clk); #1;
            check("hold_valid", 64'(resp_valid_o), 64'(N'(1) << g_exp));
            check("hold_data", 64'(resp_data_o), 64'(exp_res));
            check("hold_no_ready", 64'(req_ready_o), 64'd0);
        end
        if (dz) check("dz_unit_untouched", 64'(unit_issues), 64'(issues0));
        resp_yumi_i = N'(1) << g_exp;
        @(negedge clk);
        resp_yumi_i = '0;
        m_ptr = (g_exp + 1) % N;
        #1;
        check("resp_cleared", 64'(resp_valid_o), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(req_ready_o), 64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid_o), 64'd0);
        check({tag, "_resp_data"}, 64'(resp_data_o), 64'd0);
        check({tag, "_unit_v"}, 64'(unit_v_o), 64'd0);
        check({tag, "_unit_op_a_b"}, {30'd0, unit_op_o, unit_a_o | unit_b_o}, 64'd0);
        check({tag, "_unit_yumi"}, 64'(unit_yumi_o), 64'd0);
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        r_op[i] = op;
        r_a[i]  = a;
        r_b[i]  = b;
        req_valid_i[i] = 1'b1;
    endtask

    initial begin : stimulus
        int           g;
        logic [W-1:0] d;
        for (int i = 0; i < N; i++) begin
            r_op[i] = '0; r_a[i] = '0; r_b[i] = '0;
        end
        resp_yumi_i = '0;
        // Reset held with requests pending: nothing may be accepted.
        rst_i = 1'b1;
        req_valid_i = '1;
        #2;
        check_all_zero("reset");
        req_valid_i = '0;
        @(negedge clk); #2 rst_i = 1'b0;
        m_ptr = 0;
        @(negedge clk);

        // Single MUL 7 * -3.
        set_req(0, 2'd0, W'(7), -W'(3));
        serve(1'b0, 2, g, d);
        check("mul_grant", 64'(g), 64'd0);
        check("mul_result", 64'(d), 64'(32'hFFFF_FFEB));

        // Spurious unit valid while idle is ignored.
        spur = 1'b1;
        @(negedge clk); #2;
        check("spur_no_yumi", 64'(unit_yumi_o), 64'd0);
        check("spur_no_resp", 64'(resp_valid_o), 64'd0);
        @(negedge clk);
        spur = 1'b0;

        // Fresh reset, then both requesters continuously valid: 0,1,0,1.
        rst_i = 1'b1; #1;
        @(negedge clk); #2 rst_i = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        set_req(0, 2'd0, W'(11), W'(13));
        set_req(1, 2'd1, W'(100), -W'(7));
        for (int k = 0; k < 4; k++) begin
            serve(1'b1, k % 2, g, d);
            check("alternate_grant", 64'(g), 64'(k % 2));
        end

        // Consume withheld 10 cycles while the other requester waits.
        serve(1'b0, 10, g, d);
        check("withhold_grant", 64'(g), 64'd0);
        serve(1'b0, 0, g, d);
        check("after_withhold_grant", 64'(g), 64'd1);

        // Reserved op behaves as MUL.
        set_req(1, 2'd3, W'(5), W'(6));
        serve(1'b0, 0, g, d);
        check("op3_as_mul", 64'(d), 64'd30);

        // Reset in BUSY: a req0 op moves the pointer to 1, then req1 is in flight when reset hits.
        set_req(0, 2'd0, W'(3), W'(4));
        serve(1'b0, 0, g, d);
        slow = 1'b1;
        set_req(1, 2'd0, W'(9), W'(9));
        #1;
        for (int k = 0; k < 100 && req_ready_o == '0; k++) begin
            @(negedge clk); #1;
        end
        @(negedge clk);
        req_valid_i = '0;
        repeat (3) @(negedge clk);
        #2;
        check("busy_before_reset", 64'({unit_v_o, resp_valid_o}), 64'd0);
        rst_i = 1'b1;
        #1;
        check_all_zero("reset_busy");
        @(negedge clk); #2 rst_i = 1'b0;
        slow = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        set_req(0, 2'd2, W'(17), W'(5));
        set_req(1, 2'd2, -W'(17), W'(5));
        serve(1'b0, 0, g, d);
        check("post_reset_grant", 64'(g), 64'd0);
        serve(1'b0, 0, g, d);
        check("post_reset_grant2", 64'(g), 64'd1);

        // Divide and remainder by zero.
        set_req(0, 2'd1, W'(100), W'(0));
        serve(1'b0, 1, g, d);
        check("div_by_zero", 64'(d), 64'(32'hFFFF_FFFF));
        set_req(1, 2'd2, W'(100), W'(0));
        serve(1'b0, 1, g, d);
        check("rem_by_zero", 64'(d), 64'd100);

        // Randomized traffic with spurious unit valids enabled.
        spur = 1'b1;
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid_i[i] || $urandom_range(0, 1) == 0) begin
                    r_op[i] = 2'($urandom_range(0, 3));
                    r_a[i]  = rnd_opnd(1'b0);
                    r_b[i]  = rnd_opnd(1'b1);
                end
                req_valid_i[i] = ($urandom_range(0, 2) != 0);
            end
            if (req_valid_i == '0) req_valid_i[$urandom_range(0, N-1)] = 1'b1;
            serve(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), g, d);
        end
        spur = 1'b0;
        req_valid_i = '0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
